dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 12, byte-address width of the data RAM.
REQ-002 Parameter DWIDTH, default 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_req  input  1  port A (core MemoryAccess) request; held until a_ack.
REQ-006 a_wr  input  1  port A: 1 = write, 0 = read.
REQ-007 a_size  input  2  port A size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-008 a_addr  input  AWIDTH  port A byte address.
REQ-009 a_wdata  input  DWIDTH  port A write data, LSB-aligned.
REQ-010 a_ack  output  1  port A completion, one-cycle pulse.
REQ-011 a_err  output  1  port A error flag, valid only with a_ack.
REQ-012 a_rdata  output  DWIDTH  port A read data, valid only with a_ack.
REQ-013 b_req, b_wr, b_size, b_addr, b_wdata, b_ack, b_err, b_rdata: port B (loader/debug), identical to REQ-005..REQ-012.
REQ-014 ram_addr  output  AWIDTH  RAM byte address.
REQ-015 ram_wdata  output  DWIDTH  RAM write data.
REQ-016 ram_we  output  3  RAM write control {enable, size[1:0]}; 3'b000 = no write.
REQ-017 ram_rdata  input  DWIDTH  RAM read data, registered in RAM, one cycle after address.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE -> ACCESS on a legal grant; IDLE -> RESP on an erroneous grant; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-019 In IDLE with any req high, a grant is made; winner's wr/size/addr/wdata and port ID are latched in that cycle.
REQ-020 Arbitration is round-robin: with both requesting, the port not granted last wins; with one requesting, it wins; last-grant updates on every grant.
REQ-021 Error conditions: size = 11; halfword with addr[0] = 1; word with addr[1:0] != 00.
REQ-022 ACCESS: ram_addr/ram_wdata driven from latched values; ram_we = {1, size} for writes, 000 for reads.
REQ-023 ram_we is 000 in every state other than ACCESS and for every erroneous request.
REQ-024 ram_addr and ram_wdata hold their latched values outside ACCESS.
REQ-025 RESP: granted port's ack pulses high for exactly one cycle; the other port's ack stays 0.
REQ-026 Read rdata in RESP = ram_rdata masked by size: byte {24'b0, [7:0]}, halfword {16'b0, [15:0]}, word unmasked.
REQ-027 Write rdata = 0; err = 0 on legal requests, 1 on errors with rdata = 0.
REQ-028 Latency: legal request accepted in cycle N acks in cycle N+2; erroneous request acks in cycle N+1.
REQ-029 Earliest next grant is the cycle after RESP; legal-access throughput is one per 3 cycles.
REQ-030 A request withdrawn before ack still completes and acks; no request is queued while not in IDLE.
REQ-031 a_ack and b_ack are never high in the same cycle.

Reset
REQ-032 rst asserted: state = IDLE; last-grant = B, so A wins the first contention.
REQ-033 While rst is high: all acks, errs, rdata, ram_we, ram_addr, and ram_wdata are 0.
REQ-034 Reset mid-transaction aborts it: no ack; no ram_we after rst deasserts unless a new grant is made.

Verification
REQ-035 After reset, A write word addr 0x010 data 0xDEADBEEF -> ram_we = 110 at N+1, a_ack at N+2, a_err = 0; then A read word 0x010 -> a_rdata = 0xDEADBEEF.
REQ-036 A and B both request in the same cycle three times back-to-back -> grant order A, B, A; acks never overlap.
REQ-037 B read byte at 0x013 after REQ-035 -> b_rdata = 0x000000DE; B read halfword at 0x012 -> 0x0000DEAD.
REQ-038 A write word at 0x011, A halfword at 0x013, A size 11 -> each gives a_ack with a_err = 1 at N+1; ram_we stays 000; memory unchanged.
REQ-039 rst pulsed during ACCESS of a B write -> no b_ack, ram_we = 000 after reset; next contention is granted to A.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single data RAM.
//
// Port summary
//   clk, rst                      clock, asynchronous active-high reset
//   a_* (req/wr/size/addr/wdata)  port A request, held until a_ack
//   a_ack/a_err/a_rdata           port A one-cycle response
//   b_*                           port B, identical to port A
//   ram_addr/ram_wdata/ram_we     RAM command, ram_we = {enable, size}
//   ram_rdata                     RAM read data, one cycle after address
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch happen here
// ACCESS | latched command presented to the RAM
// RESP   | one-cycle ack to the granted port
module dmem_arbiter #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [1:0]        a_size,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [1:0]        b_size,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DWIDTH-1:0] b_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    output logic [2:0]        ram_we,
    input  logic [DWIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              last_b_q;   // 1 = port B received the most recent grant
    logic              port_q;     // 1 = current transaction belongs to port B
    logic              wr_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;

    logic              grant;
    logic              grant_b;
    logic              g_wr;
    logic [1:0]        g_size;
    logic [AWIDTH-1:0] g_addr;
    logic [DWIDTH-1:0] g_wdata;
    logic              g_err;
    logic [DWIDTH-1:0] rdata_resp;

    // B wins only if A is absent, or both request and A was served last.
    always_comb begin
        grant   = a_req | b_req;
        grant_b = b_req & (~a_req | ~last_b_q);
        g_wr    = grant_b ? b_wr    : a_wr;
        g_size  = grant_b ? b_size  : a_size;
        g_addr  = grant_b ? b_addr  : a_addr;
        g_wdata = grant_b ? b_wdata : a_wdata;
        g_err   = (g_size == 2'b11)
                | ((g_size == 2'b01) & g_addr[0])
                | ((g_size == 2'b10) & (g_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
            port_q   <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if ((state_q == IDLE) && grant) begin
            last_b_q <= grant_b;
            port_q   <= grant_b;
            wr_q     <= g_wr;
            err_q    <= g_err;
            size_q   <= g_size;
            addr_q   <= g_addr;
            wdata_q  <= g_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = g_err ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM returns data LSB-aligned; only the bytes covered by size survive.
    always_comb begin
        case (size_q)
            2'b00:   rdata_resp = {{(DWIDTH-8){1'b0}}, ram_rdata[7:0]};
            2'b01:   rdata_resp = {{(DWIDTH-16){1'b0}}, ram_rdata[15:0]};
            default: rdata_resp = ram_rdata;
        endcase
        if (wr_q || err_q) begin
            rdata_resp = '0;
        end
    end

    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_we    = 3'b000;
        a_ack     = 1'b0;
        a_err     = 1'b0;
        a_rdata   = '0;
        b_ack     = 1'b0;
        b_err     = 1'b0;
        b_rdata   = '0;
        if ((state_q == ACCESS) && wr_q && !err_q) begin
            ram_we = {1'b1, size_q};
        end
        if (state_q == RESP) begin
            if (port_q) begin
                b_ack   = 1'b1;
                b_err   = err_q;
                b_rdata = rdata_resp;
            end else begin
                a_ack   = 1'b1;
                a_err   = err_q;
                a_rdata = rdata_resp;
            end
        end
    end

endmodule
